// File: rtl/if_fetch.sv
// Instruction-fetch stage: single-outstanding-request fetch FSM feeding the IF/ID register.
// Optional stall counter output stallCount is enabled by defining IF_FETCH_PERF_EN.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        freeze,
    input  logic        redirect,
    input  logic [31:0] redirectPC,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memAck,
    input  logic [31:0] memData,
    output logic [31:0] PCOut,
    output logic [31:0] instOut,
    output logic        ifidFlush,
`ifdef IF_FETCH_PERF_EN
    output logic        ifidFreeze,
    output logic [31:0] stallCount
`else
    output logic        ifidFreeze
`endif
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_pc_q, hold_pc_d;

    logic [31:0] target;
    logic [31:0] addr_inc;
    logic        ack_v;
    logic        flush;
    logic [31:0] pc_out;
    logic [31:0] inst_out;

    assign target   = redirectPC & 32'hFFFF_FFFC;
    assign addr_inc = addr_q + 32'd4;
    // An ack with no request outstanding (e.g. left over from before reset) is ignored.
    assign ack_v    = req_q & memAck;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_d       = req_q;
        addr_d      = addr_q;
        hold_inst_d = hold_inst_q;
        hold_pc_d   = hold_pc_q;
        flush       = 1'b1;
        inst_out    = hold_inst_q;
        pc_out      = hold_pc_q;

        case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_d = target;
                    if (ack_v || !req_q) begin
                        req_d  = 1'b1;
                        addr_d = target;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (!req_q) begin
                    req_d  = 1'b1;
                    addr_d = pc_q;
                end else if (ack_v) begin
                    flush    = 1'b0;
                    inst_out = memData;
                    pc_out   = addr_inc;
                    pc_d     = addr_inc;
                    if (freeze) begin
                        hold_inst_d = memData;
                        hold_pc_d   = addr_inc;
                        req_d       = 1'b0;
                        state_d     = HOLD;
                    end else begin
                        addr_d = addr_inc;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    req_d   = 1'b1;
                    addr_d  = target;
                    state_d = FETCH;
                end else begin
                    flush = 1'b0;
                    if (!freeze) begin
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = FETCH;
                    end
                end
            end
            DRAIN: begin
                // The stale response is dropped; pc_q holds the latest redirect target.
                if (redirect) begin
                    pc_d = target;
                end
                if (ack_v) begin
                    req_d   = 1'b1;
                    addr_d  = redirect ? target : pc_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (reset) begin
            flush    = 1'b1;
            inst_out = '0;
            pc_out   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            req_q       <= 1'b0;
            addr_q      <= RESET_PC;
            hold_inst_q <= '0;
            hold_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            hold_inst_q <= hold_inst_d;
            hold_pc_q   <= hold_pc_d;
        end
    end

    assign memReq     = req_q;
    assign memAddr    = addr_q;
    assign PCOut      = pc_out;
    assign instOut    = inst_out;
    assign ifidFlush  = flush;
    assign ifidFreeze = freeze;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((flush || freeze) && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stallCount = stall_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: latency-configurable memory model with a scoreboard of
// expected IF/ID presentations, plus a second instance with RESET_PC at the top of memory.
module tb_if_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        freeze;
    logic        redirect;
    logic [31:0] redirectPC;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memData;
    logic [31:0] PCOut;
    logic [31:0] instOut;
    logic        ifidFlush;
    logic        ifidFreeze;

    logic        freeze1;
    logic        redirect1 = 1'b0;
    logic [31:0] redirectPC1 = 32'h0;
    logic        memAck1 = 1'b1;
    logic [31:0] memData1 = 32'h1357_9BDF;
    logic        memReq1;
    logic [31:0] memAddr1;
    logic [31:0] PCOut1;
    logic [31:0] instOut1;
    logic        ifidFlush1;
    logic        ifidFreeze1;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] stallCount;
    logic [31:0] stallCount1;
`endif

    if_fetch u_dut (
        .clk       (clk),
        .reset     (reset),
        .freeze    (freeze),
        .redirect  (redirect),
        .redirectPC(redirectPC),
        .memReq    (memReq),
        .memAddr   (memAddr),
        .memAck    (memAck),
        .memData   (memData),
        .PCOut     (PCOut),
        .instOut   (instOut),
        .ifidFlush (ifidFlush),
`ifdef IF_FETCH_PERF_EN
        .ifidFreeze(ifidFreeze),
        .stallCount(stallCount)
`else
        .ifidFreeze(ifidFreeze)
`endif
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_top (
        .clk       (clk),
        .reset     (reset),
        .freeze    (freeze1),
        .redirect  (redirect1),
        .redirectPC(redirectPC1),
        .memReq    (memReq1),
        .memAddr   (memAddr1),
        .memAck    (memAck1),
        .memData   (memData1),
        .PCOut     (PCOut1),
        .instOut   (instOut1),
        .ifidFlush (ifidFlush1),
`ifdef IF_FETCH_PERF_EN
        .ifidFreeze(ifidFreeze1),
        .stallCount(stallCount1)
`else
        .ifidFreeze(ifidFreeze1)
`endif
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } pres_t;

    pres_t       sbq[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    int unsigned lat;
    int unsigned wcnt;
    logic [31:0] exp_addr;
    logic [31:0] pend;
    logic        discard;

    logic        s_req;
    logic        s_flush;
    logic [31:0] s_inst;
    logic [31:0] s_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: memory answers after `lat` cycles of an outstanding request.
    task automatic step(input logic fr, input logic rd, input logic [31:0] rpc);
        logic  ack;
        logic  req;
        pres_t e;
        @(negedge clk);
        freeze     = fr;
        redirect   = rd;
        redirectPC = rpc;
        req        = memReq;
        ack        = req && (wcnt == lat - 1);
        memAck     = ack;
        memData    = ack ? mem_word(exp_addr) : 32'hBAD0_BAD0;
        #1;
        s_req   = memReq;
        s_flush = ifidFlush;
        s_inst  = instOut;
        s_addr  = memAddr;
        check_eq("ifidFreeze", ifidFreeze, fr);
        if (req) check_eq("memAddr", memAddr, exp_addr);
        if (rd) check_eq("flush_redirect", ifidFlush, 1);
        else if (ack && !discard) check_eq("flush_ack", ifidFlush, 0);
        else if (req) check_eq("flush_wait", ifidFlush, 1);

        if (rd) sbq.delete();
        if (ack && !rd && !discard) begin
            e.inst = mem_word(exp_addr);
            e.pc   = exp_addr + 32'd4;
            sbq.push_back(e);
        end
        if (!ifidFlush && !fr) begin
            if (sbq.size() == 0) begin
                check_eq("sb_unexpected_present", ifidFlush, 1);
            end else begin
                e = sbq.pop_front();
                check_eq("instOut", instOut, e.inst);
                check_eq("PCOut", PCOut, e.pc);
            end
        end

        if (rd && (ack || !req)) begin
            exp_addr = rpc & 32'hFFFF_FFFC;
            discard  = 1'b0;
        end else if (rd) begin
            discard = 1'b1;
            pend    = rpc & 32'hFFFF_FFFC;
        end else if (ack) begin
            if (discard) begin
                exp_addr = pend;
                discard  = 1'b0;
            end else begin
                exp_addr = exp_addr + 32'd4;
            end
        end
        if (req && !ack) wcnt++;
        else wcnt = 0;
        @(posedge clk);
    endtask

    task automatic drain_sb(input int unsigned budget);
        int unsigned n = 0;
        while (sbq.size() != 0 && n < budget) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        check_eq("sb_drain", sbq.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_req"}, memReq, 0);
        check_eq({tag, "_addr"}, memAddr, 32'h0);
        check_eq({tag, "_pcout"}, PCOut, 32'h0);
        check_eq({tag, "_inst"}, instOut, 32'h0);
        check_eq({tag, "_flush"}, ifidFlush, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Second instance: RESET_PC wrap and stall accounting.
    initial begin
        freeze1 = 1'b0;
        @(negedge reset);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("top_req", memReq1, 1);
        check_eq("top_addr0", memAddr1, 32'hFFFF_FFFC);
        check_eq("top_pcout0", PCOut1, 32'h0);
        check_eq("top_inst0", instOut1, 32'h1357_9BDF);
        check_eq("top_flush0", ifidFlush1, 0);
        @(negedge clk);
        #1;
        check_eq("top_addr1", memAddr1, 32'h0);
        check_eq("top_pcout1", PCOut1, 32'h4);
`ifdef IF_FETCH_PERF_EN
        check_eq("stall_initial", stallCount1, 32'd1);
`endif
        @(negedge clk);
        freeze1 = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("top_freeze_out", ifidFreeze1, 1);
        freeze1 = 1'b0;
        #1;
        check_eq("top_hold_req", memReq1, 0);
        check_eq("top_hold_inst", instOut1, 32'h1357_9BDF);
        check_eq("top_hold_pc", PCOut1, 32'h8);
        check_eq("top_hold_flush", ifidFlush1, 0);
`ifdef IF_FETCH_PERF_EN
        check_eq("stall_count", stallCount1, 32'd6);
`endif
    end

    initial begin
        reset = 1'b1; freeze = 1'b0; redirect = 1'b0; redirectPC = '0;
        memAck = 1'b0; memData = '0;
        lat = 1; wcnt = 0; exp_addr = 32'h0; pend = 32'h0; discard = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        memAck = 1'b1;
        #1;
        check_reset_state("reset");
        @(negedge clk);
        reset  = 1'b0;
        memAck = 1'b0;

        // Zero-wait streaming
        step(1'b0, 1'b0, 32'h0);
        check_eq("req_after_reset", s_req, 1);
        repeat (5) step(1'b0, 1'b0, 32'h0);

        // Three-cycle memory latency
        lat = 3;
        repeat (9) step(1'b0, 1'b0, 32'h0);

        // Freeze coincident with an ack
        lat = 1;
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check_eq("hold_req", s_req, 0);
        check_eq("hold_flush", s_flush, 0);
        if (sbq.size() != 0) check_eq("hold_inst", s_inst, sbq[0].inst);
        else check_eq("hold_sb", sbq.size(), 1);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check_eq("req_after_hold", s_req, 1);

        // Redirect with request outstanding -> drain
        lat = 3;
        step(1'b0, 1'b1, 32'h0000_1003);
        repeat (2) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check_eq("drain_target", s_addr, 32'h0000_1000);
        repeat (5) step(1'b0, 1'b0, 32'h0);

        // Two redirects while draining: last target wins
        step(1'b0, 1'b1, 32'h0000_3000);
        step(1'b0, 1'b1, 32'h0000_2008);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check_eq("drain_last_wins", s_addr, 32'h0000_2008);
        repeat (5) step(1'b0, 1'b0, 32'h0);

        // Redirect with ack, and redirect while held
        lat = 1;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0040);
        step(1'b0, 1'b0, 32'h0);
        check_eq("redir_ack_addr", s_addr, 32'h0000_0040);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0080);
        step(1'b0, 1'b0, 32'h0);
        check_eq("redir_hold_req", s_req, 1);
        check_eq("redir_hold_addr", s_addr, 32'h0000_0080);

        // PC wrap at the top of the address space
        step(1'b0, 1'b1, 32'hFFFF_FFFE);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check_eq("wrap_addr", s_addr, 32'h0);
        drain_sb(4);

        // Reset mid-transaction, then a stray ack before memReq returns
        lat = 3;
        step(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b1; memAck = 1'b0; freeze = 1'b0; redirect = 1'b0;
        @(negedge clk);
        #1;
        check_reset_state("midreset");
        reset   = 1'b0;
        memAck  = 1'b1;
        memData = 32'h0BAD_F00D;
        #1;
        check_eq("stray_ack_flush", ifidFlush, 1);
        check_eq("stray_ack_inst", instOut, 32'h0);
        exp_addr = 32'h0; wcnt = 0; discard = 1'b0;
        sbq.delete();
        step(1'b0, 1'b0, 32'h0);
        check_eq("req_after_midreset", s_req, 1);
        lat = 2;
        repeat (8) step(1'b0, 1'b0, 32'h0);
        drain_sb(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
